// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues requests to inst_axi, and buffers
// fetched {pc, inst, adel} entries in a small FIFO drained by decode.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_o,
  output logic        pc_en_o,
  output logic        flush_o,
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel,
  input  logic        out_ready
);

  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StFetch, StFault} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [31:0]        pc_mem   [FIFO_DEPTH];
  logic [31:0]        inst_mem [FIFO_DEPTH];
  logic               adel_mem [FIFO_DEPTH];

  logic full;
  logic misaligned;
  logic can_fetch;
  logic accept;
  logic fault_push;
  logic push;
  logic pop;

  // Request/push/pop decode and FSM next-state
  always_comb begin
    full       = (count_q == DepthCnt);
    misaligned = (pc_q[1:0] != 2'b00);
    can_fetch  = ~reset & ~redirect_valid & ~full & (state_q == StFetch);

    pc_en_o    = can_fetch & ~misaligned;
    flush_o    = redirect_valid;
    accept     = pc_en_o & inst_valid_i;
    fault_push = can_fetch & misaligned;
    push       = accept | fault_push;
    // A pop alongside a redirect is void: the queue is cleared anyway.
    pop        = (count_q != '0) & out_ready & ~redirect_valid;

    state_d = state_q;
    if (redirect_valid) begin
      state_d = StFetch;
    end else if (fault_push) begin
      state_d = StFault;
    end
  end

  // Fetch PC and FIFO bookkeeping next-state
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; fault entries carry a zero instruction word
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= fault_push ? 32'h0 : inst_i;
      adel_mem[wr_ptr_q] <= fault_push;
    end
  end

  // Head-of-queue outputs
  always_comb begin
    pc_o      = pc_q;
    out_valid = (count_q != '0);
    out_pc    = pc_mem[rd_ptr_q];
    out_inst  = inst_mem[rd_ptr_q];
    out_adel  = adel_mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue.
module tb_inst_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_o;
  logic        pc_en_o;
  logic        flush_o;
  logic [31:0] inst_i;
  logic        inst_valid_i;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;
  logic        out_ready;

  int checks;
  int failures;

  inst_fetch_queue #(
    .RESET_PC   (32'hBFC0_0000),
    .FIFO_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_o           (pc_o),
    .pc_en_o        (pc_en_o),
    .flush_o        (flush_o),
    .inst_i         (inst_i),
    .inst_valid_i   (inst_valid_i),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_adel       (out_adel),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_i         = 32'h0;
    inst_valid_i   = 1'b0;
    out_ready      = 1'b0;

    // Reset behaviour
    tick();
    tick();
    settle();
    check("rst_pc", pc_o, 32'hBFC0_0000);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pc_en", {31'b0, pc_en_o}, 32'd0);
    redirect_valid = 1'b1;
    settle();
    check("rst_flush_follows", {31'b0, flush_o}, 32'd1);
    redirect_valid = 1'b0;
    settle();
    check("rst_flush_low", {31'b0, flush_o}, 32'd0);
    tick();
    reset = 1'b0;

    // Test 1: streaming hits with decode always ready
    inst_valid_i = 1'b1;
    out_ready    = 1'b1;
    inst_i       = 32'h1111_0000;
    settle();
    check("t1_pc_en", {31'b0, pc_en_o}, 32'd1);
    check("t1_pc0", pc_o, 32'hBFC0_0000);
    check("t1_empty", {31'b0, out_valid}, 32'd0);
    tick();
    check("t1_pc1", pc_o, 32'hBFC0_0004);
    check("t1_valid1", {31'b0, out_valid}, 32'd1);
    check("t1_out_pc1", out_pc, 32'hBFC0_0000);
    check("t1_out_inst1", out_inst, 32'h1111_0000);
    inst_i = 32'h1111_0004;
    tick();
    check("t1_pc2", pc_o, 32'hBFC0_0008);
    check("t1_valid2", {31'b0, out_valid}, 32'd1);
    check("t1_out_pc2", out_pc, 32'hBFC0_0004);
    check("t1_out_inst2", out_inst, 32'h1111_0004);

    // Test 2: fill the queue from a fresh reset, then pop once
    reset        = 1'b1;
    inst_valid_i = 1'b0;
    out_ready    = 1'b0;
    tick();
    reset        = 1'b0;
    inst_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_i = 32'h2222_0000 + 32'(i);
      tick();
    end
    check("t2_pc_full", pc_o, 32'hBFC0_0010);
    check("t2_pc_en_full", {31'b0, pc_en_o}, 32'd0);
    check("t2_head_pc", out_pc, 32'hBFC0_0000);
    check("t2_head_inst", out_inst, 32'h2222_0000);
    tick();
    check("t2_pc_hold_full", pc_o, 32'hBFC0_0010);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    settle();
    check("t2_pc_en_after_pop", {31'b0, pc_en_o}, 32'd1);
    check("t2_pc_after_pop", pc_o, 32'hBFC0_0010);
    check("t2_head_after_pop", out_pc, 32'hBFC0_0004);
    check("t2_head_inst_after_pop", out_inst, 32'h2222_0001);

    // Test 3: five miss cycles hold the PC, then a single hit
    inst_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t3_miss_pc_en", {31'b0, pc_en_o}, 32'd1);
      check("t3_miss_pc", pc_o, 32'hBFC0_0010);
      tick();
    end
    check("t3_head_unchanged", out_pc, 32'hBFC0_0004);
    inst_valid_i = 1'b1;
    inst_i       = 32'h3333_0010;
    tick();
    check("t3_pc_after_hit", pc_o, 32'hBFC0_0014);
    check("t3_full_again", {31'b0, pc_en_o}, 32'd0);

    // Test 4: redirect with three entries queued and a hit present
    inst_valid_i = 1'b0;
    out_ready    = 1'b1;
    tick();
    check("t4_head_before", out_pc, 32'hBFC0_0008);
    out_ready      = 1'b0;
    inst_valid_i   = 1'b1;
    inst_i         = 32'hDEAD_BEEF;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    settle();
    check("t4_flush", {31'b0, flush_o}, 32'd1);
    check("t4_pc_en_redirect", {31'b0, pc_en_o}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("t4_cleared", {31'b0, out_valid}, 32'd0);
    check("t4_new_pc", pc_o, 32'h8000_0100);
    check("t4_flush_low", {31'b0, flush_o}, 32'd0);
    check("t4_pc_en_new", {31'b0, pc_en_o}, 32'd1);
    inst_i = 32'h4444_0100;
    tick();
    check("t4_first_valid", {31'b0, out_valid}, 32'd1);
    check("t4_first_pc", out_pc, 32'h8000_0100);
    check("t4_first_inst", out_inst, 32'h4444_0100);
    check("t4_first_adel", {31'b0, out_adel}, 32'd0);
    check("t4_pc_next", pc_o, 32'h8000_0104);

    // Test 5: misaligned redirect target produces one fault entry
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    inst_i         = 32'h5555_5555;
    settle();
    check("t5_pc_en_misaligned", {31'b0, pc_en_o}, 32'd0);
    check("t5_empty", {31'b0, out_valid}, 32'd0);
    tick();
    check("t5_valid", {31'b0, out_valid}, 32'd1);
    check("t5_adel", {31'b0, out_adel}, 32'd1);
    check("t5_inst_zero", out_inst, 32'h0);
    check("t5_out_pc", out_pc, 32'h8000_0102);
    check("t5_pc_held", pc_o, 32'h8000_0102);
    check("t5_pc_en_fault", {31'b0, pc_en_o}, 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("t5_single_entry", {31'b0, out_valid}, 32'd0);
    check("t5_pc_en_stays_low", {31'b0, pc_en_o}, 32'd0);

    // Test 6: PC wrap at 2^32 and pointer wrap with in-order delivery
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    inst_i         = 32'h6666_FFFC;
    settle();
    check("t6_pc_en_top", {31'b0, pc_en_o}, 32'd1);
    tick();
    check("t6_pc_wrap", pc_o, 32'h0000_0000);
    check("t6_head_top", out_pc, 32'hFFFF_FFFC);
    check("t6_inst_top", out_inst, 32'h6666_FFFC);
    for (int i = 0; i < 10; i++) begin
      inst_i = 32'hC0DE_0000 + 32'(i);
      tick();
      check("t6_order_pc", out_pc, 32'(4 * i));
      check("t6_order_inst", out_inst, 32'hC0DE_0000 + 32'(i));
      check("t6_fetch_pc", pc_o, 32'(4 * (i + 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
